// File: rtl/cpu_bus_fabric.sv
// cpu_bus_fabric: single-master CPU bus fabric.
// It latches one request, decodes cpu_addr[31:24] against per-slave prefixes,
// and selects at most one slave. It returns exactly one cpu_ready strobe per
// accepted request. Unmapped addresses produce a zero response and a bus_err
// pulse. force_trap short-circuits the access with a zero response.
// Optional feature: define BUS_TIMEOUT_EN to bound the time spent waiting in
// ACCESS to TIMEOUT_CYCLES cycles. A timeout is reported like an unmapped
// access.
module cpu_bus_fabric #(
    parameter int                        NUM_SLAVES     = 8,
    parameter logic [8*NUM_SLAVES-1:0]   SLAVE_PREFIX   = 64'h0706050403020100,
    parameter int                        TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpu_valid,
    input  logic [31:0]                  cpu_addr,
    input  logic [31:0]                  cpu_wdata,
    input  logic [3:0]                   cpu_wstrb,
    input  logic                         force_trap,
    output logic                         cpu_ready,
    output logic [31:0]                  cpu_rdata,
    output logic [NUM_SLAVES-1:0]        slv_cs,
    output logic [31:0]                  slv_addr,
    output logic [31:0]                  slv_wdata,
    output logic [3:0]                   slv_wstrb,
    input  logic [32*NUM_SLAVES-1:0]     slv_rdata,
    input  logic [NUM_SLAVES-1:0]        slv_ready,
    output logic                         bus_err,
    output logic [31:0]                  err_addr
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    // Elaboration-time guards on the legal parameter ranges.
    if (NUM_SLAVES < 2 || NUM_SLAVES > 16) begin : g_bad_num_slaves
        $error("cpu_bus_fabric: NUM_SLAVES must be within 2..16");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("cpu_bus_fabric: TIMEOUT_CYCLES must be within 1..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               bus_err_q, bus_err_d;
    logic [31:0]        err_addr_q, err_addr_d;

    logic               hit;
    logic [SEL_W-1:0]   hit_idx;
    logic               sel_ready;
    logic [31:0]        sel_rdata;

`ifdef BUS_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]        tmo_cnt_q, tmo_cnt_d;
`endif

    // Prefix decode: scanning downward lets the lowest matching index win.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (cpu_addr[31:24] == SLAVE_PREFIX[8*i +: 8]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    assign sel_ready = slv_ready[sel_q];
    assign sel_rdata = slv_rdata[32*sel_q +: 32];

    // Next-state and register-update logic for the IDLE/ACCESS/RESP machine.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        bus_err_d  = 1'b0;
        err_addr_d = err_addr_q;
`ifdef BUS_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // cpu_ready is low here by construction, so no decode can
                // start in the cycle the previous response is strobed.
                if (cpu_valid && !cpu_ready) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    wstrb_d = cpu_wstrb;
                    if (force_trap) begin
                        rdata_d = 32'h0000_0000;
                        state_d = ST_RESP;
                    end else if (hit) begin
                        sel_d   = hit_idx;
                        state_d = ST_ACCESS;
`ifdef BUS_TIMEOUT_EN
                        tmo_cnt_d = 16'd0;
`endif
                    end else begin
                        rdata_d    = 32'h0000_0000;
                        bus_err_d  = 1'b1;
                        err_addr_d = cpu_addr;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                // A ready in the same cycle as the timeout wins.
                if (sel_ready) begin
                    rdata_d = sel_rdata;
                    state_d = ST_RESP;
                end
`ifdef BUS_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    rdata_d    = 32'h0000_0000;
                    bus_err_d  = 1'b1;
                    err_addr_d = addr_q;
                    state_d    = ST_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q    <= state_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
`endif
        end
    end

    // Chip select is derived from the state, so reset removes it immediately.
    always_comb begin
        slv_cs = '0;
        if (state_q == ST_ACCESS) begin
            slv_cs[sel_q] = 1'b1;
        end
    end

    assign cpu_ready = (state_q == ST_RESP);
    assign cpu_rdata = rdata_q;
    assign bus_err   = bus_err_q;
    assign err_addr  = err_addr_q;
    assign slv_addr  = addr_q;
    assign slv_wdata = wdata_q;
    assign slv_wstrb = wstrb_q;

endmodule

// File: tb/tb_cpu_bus_fabric.sv
// tb_cpu_bus_fabric: directed and randomized checks of cpu_bus_fabric.
// The reference model is a prefix lookup table plus a per-transaction timing
// rule. Slave 7 reuses prefix 0x03 so that the lowest-index rule is observable.
module tb_cpu_bus_fabric;

    localparam int NS  = 8;
    localparam int TMO = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cpu_valid = 1'b0;
    logic [31:0]          cpu_addr = '0;
    logic [31:0]          cpu_wdata = '0;
    logic [3:0]           cpu_wstrb = '0;
    logic                 force_trap = 1'b0;
    logic                 cpu_ready;
    logic [31:0]          cpu_rdata;
    logic [NS-1:0]        slv_cs;
    logic [31:0]          slv_addr;
    logic [31:0]          slv_wdata;
    logic [3:0]           slv_wstrb;
    logic [32*NS-1:0]     slv_rdata = '0;
    logic [NS-1:0]        slv_ready = '0;
    logic                 bus_err;
    logic [31:0]          err_addr;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_rdata    = '0;
    logic [31:0] exp_err_addr = '0;
    logic [7:0]  pfx_tab [NS];

    cpu_bus_fabric #(
        .NUM_SLAVES     (NS),
        .SLAVE_PREFIX   (64'h0306050403020100),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_valid  (cpu_valid),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_wstrb  (cpu_wstrb),
        .force_trap (force_trap),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .slv_cs     (slv_cs),
        .slv_addr   (slv_addr),
        .slv_wdata  (slv_wdata),
        .slv_wstrb  (slv_wstrb),
        .slv_rdata  (slv_rdata),
        .slv_ready  (slv_ready),
        .bus_err    (bus_err),
        .err_addr   (err_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode: first table entry holding the prefix, or -1.
    function automatic int find_slave(input logic [7:0] pfx);
        for (int i = 0; i < NS; i++) begin
            if (pfx_tab[i] == pfx) return i;
        end
        return -1;
    endfunction

    task automatic scramble_rdata();
        for (int i = 0; i < NS; i++) begin
            slv_rdata[32*i +: 32] = $urandom;
        end
    endtask

    // One request: drive at a negedge, then check every cycle up to the response.
    // 'delay' is the number of ACCESS cycles before the slave raises ready.
    task automatic run_txn(input string tag, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input logic trap, input int delay,
                           input logic rd_force, input logic [31:0] rd_val);
        int         idx;
        int         ncyc;
        logic       timed_out;
        logic       exp_err;
        logic [7:0] exp_cs;

        idx       = trap ? -1 : find_slave(addr[31:24]);
        timed_out = 1'b0;
        ncyc      = 0;
        exp_cs    = 8'h00;
        if (idx >= 0) begin
            ncyc   = delay + 1;
            exp_cs = 8'(1 << idx);
`ifdef BUS_TIMEOUT_EN
            if (delay + 1 > TMO) begin
                ncyc      = TMO;
                timed_out = 1'b1;
            end
`endif
        end
        exp_err = (!trap && idx < 0) || timed_out;

        check({tag, " idle_ready"}, 32'(cpu_ready), 32'd0);
        check({tag, " idle_cs"}, 32'(slv_cs), 32'd0);

        cpu_valid  = 1'b1;
        cpu_addr   = addr;
        cpu_wdata  = wdata;
        cpu_wstrb  = wstrb;
        force_trap = trap;
        slv_ready  = 8'($urandom);
        scramble_rdata();
        @(negedge clk);
        cpu_valid  = 1'b0;
        force_trap = 1'b0;
        cpu_addr   = $urandom;
        cpu_wdata  = $urandom;
        cpu_wstrb  = 4'($urandom);

        for (int k = 1; k <= ncyc; k++) begin
            check({tag, " cs"}, 32'(slv_cs), 32'(exp_cs));
            check({tag, " wait_ready"}, 32'(cpu_ready), 32'd0);
            if (k == 1) begin
                check({tag, " slv_addr"}, slv_addr, addr);
                check({tag, " slv_wdata"}, slv_wdata, wdata);
                check({tag, " slv_wstrb"}, 32'(slv_wstrb), 32'(wstrb));
            end
            scramble_rdata();
            slv_ready = 8'($urandom) & ~exp_cs;
            if (k == delay + 1) begin
                if (rd_force) slv_rdata[32*idx +: 32] = rd_val;
                slv_ready = slv_ready | exp_cs;
                exp_rdata = slv_rdata[32*idx +: 32];
            end
            @(negedge clk);
        end

        if (idx < 0 || timed_out) exp_rdata = 32'h0;
        if (exp_err) exp_err_addr = addr;
        slv_ready = 8'($urandom);
        check({tag, " resp_ready"}, 32'(cpu_ready), 32'd1);
        check({tag, " resp_rdata"}, cpu_rdata, exp_rdata);
        check({tag, " resp_err"}, 32'(bus_err), 32'(exp_err));
        check({tag, " err_addr"}, err_addr, exp_err_addr);
        check({tag, " resp_cs"}, 32'(slv_cs), 32'd0);
        @(negedge clk);
        slv_ready = '0;
        check({tag, " post_ready"}, 32'(cpu_ready), 32'd0);
        check({tag, " post_err"}, 32'(bus_err), 32'd0);
        check({tag, " post_rdata"}, cpu_rdata, exp_rdata);
    endtask

    initial begin
        pfx_tab = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h03};

        // Outputs while reset is held.
        @(negedge clk);
        @(negedge clk);
        check("rst ready", 32'(cpu_ready), 32'd0);
        check("rst cs", 32'(slv_cs), 32'd0);
        check("rst rdata", cpu_rdata, 32'd0);
        check("rst err", 32'(bus_err), 32'd0);
        check("rst err_addr", err_addr, 32'd0);
        check("rst slv_addr", slv_addr, 32'd0);
        check("rst slv_wstrb", 32'(slv_wstrb), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed scenarios.
        run_txn("rd_s1", 32'h0100_0010, 32'h0, 4'h0, 1'b0, 0, 1'b1, 32'hDEAD_BEEF);
        run_txn("wr_s3", 32'h0300_0004, 32'hCAFE_F00D, 4'hF, 1'b0, 5, 1'b0, 32'h0);
        run_txn("unmapped", 32'h2A00_0000, 32'h0, 4'h0, 1'b0, 0, 1'b0, 32'h0);
        run_txn("trap", 32'h0000_0000, 32'h0, 4'h0, 1'b1, 0, 1'b0, 32'h0);
        run_txn("dup_pfx", 32'h0300_0100, 32'h1111_2222, 4'h3, 1'b0, 1, 1'b0, 32'h0);
        run_txn("pfx7_unmapped", 32'h0700_0000, 32'h0, 4'h0, 1'b0, 0, 1'b0, 32'h0);
`ifdef BUS_TIMEOUT_EN
        run_txn("timeout", 32'h0200_0000, 32'h0, 4'h0, 1'b0, 1000, 1'b0, 32'h0);
        run_txn("tmo_edge", 32'h0200_0000, 32'h0, 4'h0, 1'b0, TMO - 1, 1'b0, 32'h0);
`else
        run_txn("long_wait", 32'h0200_0000, 32'h0, 4'h0, 1'b0, 20, 1'b0, 32'h0);
`endif

        // Reset in the middle of an access: cs and cpu_ready drop at once.
        cpu_valid = 1'b1;
        cpu_addr  = 32'h0500_0020;
        cpu_wdata = 32'h5555_AAAA;
        cpu_wstrb = 4'h3;
        slv_ready = '0;
        @(negedge clk);
        cpu_valid = 1'b0;
        check("mid cs1", 32'(slv_cs), 32'h20);
        @(negedge clk);
        check("mid cs2", 32'(slv_cs), 32'h20);
        #2 rst = 1'b1;
        #1;
        check("mid_rst cs", 32'(slv_cs), 32'd0);
        check("mid_rst ready", 32'(cpu_ready), 32'd0);
        check("mid_rst rdata", cpu_rdata, 32'd0);
        check("mid_rst err", 32'(bus_err), 32'd0);
        check("mid_rst err_addr", err_addr, 32'd0);
        check("mid_rst slv_addr", slv_addr, 32'd0);
        check("mid_rst slv_wdata", slv_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_rdata    = 32'h0;
        exp_err_addr = 32'h0;
        slv_ready    = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst ready", 32'(cpu_ready), 32'd0);
            check("post_rst cs", 32'(slv_cs), 32'd0);
        end
        slv_ready = '0;

        // Randomized requests: mixed prefixes, traps and slave delays.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = {8'($urandom_range(0, 15)), 24'($urandom)};
            run_txn("rand", a, $urandom, 4'($urandom), ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 6)), 1'b0, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_bus_fabric.md
CPU_BUS_FABRIC -- requirements
Module: cpu_bus_fabric

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 8, number of slave ports (legal range 2..16).
REQ-002 SHALL have parameter SLAVE_PREFIX, default 8-bit prefixes 0x00..0x07 packed, giving slave i its address prefix in bits [8i+7:8i].
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles spent waiting in ACCESS (legal range 1..65535).
REQ-004 SHALL have port clk, input, 1 bit: system clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high (already decided).
REQ-006 SHALL have port cpu_valid, input, 1 bit: CPU request valid.
REQ-007 SHALL have port cpu_addr, input, 32 bits: byte address.
REQ-008 SHALL have port cpu_wdata, input, 32 bits: write data.
REQ-009 SHALL have port cpu_wstrb, input, 4 bits: byte write strobes; 0 means read.
REQ-010 SHALL have port force_trap, input, 1 bit: return an illegal instruction instead of accessing a slave.
REQ-011 SHALL have port cpu_ready, output, 1 bit: response strobe.
REQ-012 SHALL have port cpu_rdata, output, 32 bits: response data.
REQ-013 SHALL have port slv_cs, output, NUM_SLAVES bits: one-hot slave select.
REQ-014 SHALL have ports slv_addr, slv_wdata and slv_wstrb, outputs, 32/32/4 bits: latched request, broadcast to all slaves.
REQ-015 SHALL have port slv_rdata, input, 32*NUM_SLAVES bits: slave i read data in bits [32i+31:32i].
REQ-016 SHALL have port slv_ready, input, NUM_SLAVES bits: per-slave completion.
REQ-017 SHALL have port bus_err, output, 1 bit: one-cycle error pulse.
REQ-018 SHALL have port err_addr, output, 32 bits: address of the last errored access.

Function
REQ-019 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-020 SHALL, in IDLE with cpu_valid=1 and cpu_ready=0, latch addr/wdata/wstrb and decode cpu_addr[31:24] against SLAVE_PREFIX.
REQ-021 SHALL select the lowest index when several prefixes match.
REQ-022 SHALL, in IDLE with force_trap=1, go to RESP with rdata 0x00000000 and no cs and no bus_err; force_trap SHALL take priority over decode.
REQ-023 SHALL, in IDLE with no prefix match, go to RESP with rdata 0, raise bus_err and load err_addr.
REQ-024 SHALL, in IDLE on a prefix match, go to ACCESS and store the selected index.
REQ-025 SHALL drive slv_cs[sel]=1 only while in ACCESS; slv_cs SHALL be 0 otherwise.
REQ-026 SHALL, in ACCESS when slv_ready[sel]=1, register slv_rdata[sel] into cpu_rdata and go to RESP.
REQ-027 SHALL ignore slv_ready bits of unselected slaves.
REQ-028 SHALL, in RESP, drive cpu_ready=1 for exactly one cycle, then return to IDLE.
REQ-029 SHALL hold cpu_rdata stable until the next RESP.
REQ-030 SHALL give a minimum latency of 2 cycles: valid seen in cycle 0, cs in cycle 1 with slave ready, cpu_ready in cycle 2.
REQ-031 SHALL pulse bus_err in the RESP cycle, coincident with cpu_ready.
REQ-032 SHALL NOT start a new decode in the cycle cpu_ready=1.

Reset
REQ-033 SHALL, on rst=1, immediately force: state IDLE, cpu_ready=0, cpu_rdata=0, slv_cs=0, slv_addr/wdata/wstrb=0, bus_err=0, err_addr=0, timeout counter=0.
REQ-034 SHALL, on reset during ACCESS, drop cs asynchronously and discard the transaction with no response.

Configuration
REQ-035 SHALL, with macro BUS_TIMEOUT_EN defined, count cycles spent in ACCESS (16-bit counter, cleared on ACCESS entry).
REQ-036 SHALL, with BUS_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES without a ready, go to RESP with rdata 0, bus_err=1 and err_addr loaded.
REQ-037 SHALL, with BUS_TIMEOUT_EN defined, treat slv_ready arriving in the same cycle as the timeout as a normal completion.
REQ-038 SHALL, with BUS_TIMEOUT_EN undefined, wait indefinitely in ACCESS, include no counter, and raise bus_err only for unmapped addresses.

Verification
REQ-039 SHALL cover: read 0x01000010, slave1 ready with cs, rdata 0xDEADBEEF -> cpu_ready 2 cycles later, cpu_rdata=0xDEADBEEF, bus_err=0.
REQ-040 SHALL cover: write 0x03000004, wstrb=0xF, slave3 ready after 5 cycles -> slv_cs=0x08 for 6 cycles, slv_wstrb=0xF, then one cpu_ready.
REQ-041 SHALL cover: access 0x2A000000 (unmapped) -> cpu_ready with rdata=0, bus_err pulse, err_addr=0x2A000000, slv_cs never set.
REQ-042 SHALL cover: force_trap=1 with address 0x00000000 -> cpu_rdata=0x00000000, slv_cs=0, bus_err=0.
REQ-043 SHALL cover: BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave2 never ready -> cs high 4 cycles, then cpu_ready, bus_err=1, err_addr=0x02000000.
REQ-044 SHALL cover: rst asserted mid-ACCESS -> slv_cs=0 and cpu_ready=0 in the same cycle, and all outputs zero.
